// File: rtl/beep_driver.sv
// beep_driver: plays N tone bursts separated by silent gaps on a passive-buzzer pin, then pulses done.
// Build option BEEP_ABORT_EN adds an abort input that ends a running sequence early.
module beep_driver #(
  parameter logic [24:0] HALF_DIV0 = 25'd12500,
  parameter logic [24:0] HALF_DIV1 = 25'd8333,
  parameter logic [24:0] HALF_DIV2 = 25'd6250,
  parameter logic [24:0] HALF_DIV3 = 25'd5000,
  parameter logic [24:0] ON_CYC    = 25'd5000000,
  parameter logic [24:0] OFF_CYC   = 25'd5000000
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       req,
  input  logic [1:0] tone_sel,
  input  logic [2:0] beep_num,
`ifdef BEEP_ABORT_EN
  input  logic       abort,
`endif
  output logic       beep,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ON   = 2'd1,
    S_OFF  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  tone_q, tone_d;
  logic [2:0]  rem_q, rem_d;
  logic [24:0] tone_cnt_q, tone_cnt_d;
  logic [24:0] dur_cnt_q, dur_cnt_d;
  logic        beep_q, beep_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [24:0] half_s;
  logic        abort_s;

`ifdef BEEP_ABORT_EN
  assign abort_s = abort;
`else
  assign abort_s = 1'b0;
`endif

  // Half-period of the tone latched at acceptance
  always_comb begin
    case (tone_q)
      2'd0:    half_s = HALF_DIV0;
      2'd1:    half_s = HALF_DIV1;
      2'd2:    half_s = HALF_DIV2;
      default: half_s = HALF_DIV3;
    endcase
  end

  // Next-state and next-output logic; outputs are computed one cycle ahead and registered
  always_comb begin
    state_d    = state_q;
    tone_d     = tone_q;
    rem_d      = rem_q;
    tone_cnt_d = tone_cnt_q;
    dur_cnt_d  = dur_cnt_q;
    beep_d     = 1'b0;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          tone_d     = tone_sel;
          rem_d      = beep_num;
          tone_cnt_d = 25'd0;
          dur_cnt_d  = 25'd0;
          if (beep_num == 3'd0) begin
            // Empty request: completion pulse only, never reported busy
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_ON;
            beep_d  = 1'b1;
            busy_d  = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ON: begin
        busy_d = 1'b1;
        if (abort_s) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else if (dur_cnt_q == ON_CYC - 25'd1) begin
          rem_d      = rem_q - 3'd1;
          dur_cnt_d  = 25'd0;
          tone_cnt_d = 25'd0;
          if (rem_q == 3'd1) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_OFF;
          end
        end else begin
          dur_cnt_d = dur_cnt_q + 25'd1;
          if (tone_cnt_q == half_s - 25'd1) begin
            tone_cnt_d = 25'd0;
            beep_d     = ~beep_q;
          end else begin
            tone_cnt_d = tone_cnt_q + 25'd1;
            beep_d     = beep_q;
          end
        end
      end
      S_OFF: begin
        busy_d = 1'b1;
        if (abort_s) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else if (dur_cnt_q == OFF_CYC - 25'd1) begin
          // Tone phase restarts high at the start of every burst
          state_d    = S_ON;
          dur_cnt_d  = 25'd0;
          tone_cnt_d = 25'd0;
          beep_d     = 1'b1;
        end else begin
          dur_cnt_d = dur_cnt_q + 25'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, counters and registered outputs with synchronous reset
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q    <= S_IDLE;
      tone_q     <= 2'd0;
      rem_q      <= 3'd0;
      tone_cnt_q <= 25'd0;
      dur_cnt_q  <= 25'd0;
      beep_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tone_q     <= tone_d;
      rem_q      <= rem_d;
      tone_cnt_q <= tone_cnt_d;
      dur_cnt_q  <= dur_cnt_d;
      beep_q     <= beep_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign beep = beep_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_beep_driver.sv
// Scoreboard bench for beep_driver: per-cycle expected {beep,busy,done} are queued with the
// stimulus and popped one per clock. Define BEEP_ABORT_EN to include the abort scenario.
module tb_beep_driver;

  localparam int H0  = 2;
  localparam int H1  = 3;
  localparam int H2  = 4;
  localparam int H3  = 5;
  localparam int ON  = 8;
  localparam int OFF = 4;

  logic       sys_clk = 1'b0;
  logic       sys_rst;
  logic       req;
  logic [1:0] tone_sel;
  logic [2:0] beep_num;
  logic       beep;
  logic       busy;
  logic       done;
`ifdef BEEP_ABORT_EN
  logic       abort;
`endif

  typedef struct {
    logic [2:0] v;
    string      tag;
    int         idx;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass  = 0;
  int   n_total = 0;
  int   n_fail  = 0;
  int   n_idx   = 0;

  always #5 sys_clk = ~sys_clk;

  beep_driver #(
    .HALF_DIV0 (25'd2),
    .HALF_DIV1 (25'd3),
    .HALF_DIV2 (25'd4),
    .HALF_DIV3 (25'd5),
    .ON_CYC    (25'd8),
    .OFF_CYC   (25'd4)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .req      (req),
    .tone_sel (tone_sel),
    .beep_num (beep_num),
`ifdef BEEP_ABORT_EN
    .abort    (abort),
`endif
    .beep     (beep),
    .busy     (busy),
    .done     (done)
  );

  task automatic push(input string tag, input logic [2:0] v);
    exp_t e;
    e.v   = v;
    e.tag = tag;
    e.idx = n_idx;
    n_idx++;
    exp_q.push_back(e);
  endtask

  // Expected trace of a whole sequence, cycle 1 (first cycle after acceptance) onward
  task automatic push_seq(input string tag, input int half, input int n);
    n_idx = 1;
    if (n == 0) begin
      push(tag, 3'b001);
    end else begin
      for (int b = 0; b < n; b++) begin
        for (int i = 0; i < ON; i++)
          push(tag, {(((i / half) % 2) == 0) ? 1'b1 : 1'b0, 1'b1, 1'b0});
        if (b < n - 1)
          for (int i = 0; i < OFF; i++) push(tag, 3'b010);
      end
      push(tag, 3'b011);
    end
    push(tag, 3'b000);
  endtask

  task automatic tick();
    exp_t       e;
    logic [2:0] obs;
    @(posedge sys_clk);
    #1;
    obs = {beep, busy, done};
    n_total++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $error("FAIL underflow: {beep,busy,done} got %b expected no pending entry", obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e.v) begin
        n_pass++;
      end else begin
        n_fail++;
        $error("FAIL %s[%0d]: {beep,busy,done} got %b expected %b", e.tag, e.idx, obs, e.v);
      end
    end
  endtask

  task automatic drain();
    while (exp_q.size() > 0) tick();
  endtask

  initial begin
    sys_rst  = 1'b1;
    req      = 1'b1;
    tone_sel = 2'd0;
    beep_num = 3'd1;
`ifdef BEEP_ABORT_EN
    abort    = 1'b0;
`endif

    // Reset held 3 cycles with req high: nothing may start
    n_idx = 1;
    for (int i = 0; i < 3; i++) push("reset", 3'b000);
    drain();
    sys_rst = 1'b0;
    req     = 1'b0;
    n_idx = 1;
    for (int i = 0; i < 2; i++) push("post_reset", 3'b000);
    drain();

    // Single burst, tone 0
    push_seq("tone0_n1", H0, 1);
    tone_sel = 2'd0; beep_num = 3'd1; req = 1'b1;
    tick();
    req = 1'b0;
    drain();

    // Three bursts, tone 1
    push_seq("tone1_n3", H1, 3);
    tone_sel = 2'd1; beep_num = 3'd3; req = 1'b1;
    tick();
    req = 1'b0;
    drain();

    // Zero bursts: done only, never busy
    push_seq("n0", H0, 0);
    tone_sel = 2'd2; beep_num = 3'd0; req = 1'b1;
    tick();
    req = 1'b0;
    drain();

    // Tones 2 and 3 select their own half-periods
    push_seq("tone2_n1", H2, 1);
    tone_sel = 2'd2; beep_num = 3'd1; req = 1'b1;
    tick();
    req = 1'b0;
    drain();
    push_seq("tone3_n1", H3, 1);
    tone_sel = 2'd3; beep_num = 3'd1; req = 1'b1;
    tick();
    req = 1'b0;
    drain();

    // req and input changes mid-burst are ignored
    push_seq("ignore", H0, 2);
    tone_sel = 2'd0; beep_num = 3'd2; req = 1'b1;
    tick();
    req = 1'b0;
    tick();
    tick();
    req = 1'b1; tone_sel = 2'd1; beep_num = 3'd5;
    tick();
    req = 1'b0;
    drain();

    // req held high: ignored during DONE, retriggers on the following IDLE cycle
    push_seq("hold_a", H0, 1);
    push_seq("hold_b", H0, 1);
    tone_sel = 2'd0; beep_num = 3'd1; req = 1'b1;
    for (int i = 0; i < 11; i++) tick();
    req = 1'b0;
    drain();

    // Reset during cycle 5 of a burst: outputs clear, no done pulse
    n_idx = 1;
    for (int i = 0; i < 5; i++)
      push("rst_mid", {(((i / H0) % 2) == 0) ? 1'b1 : 1'b0, 1'b1, 1'b0});
    tone_sel = 2'd0; beep_num = 3'd1; req = 1'b1;
    tick();
    req = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    sys_rst = 1'b1;
    push("rst_mid", 3'b000);
    tick();
    sys_rst = 1'b0;
    for (int i = 0; i < 3; i++) push("rst_mid", 3'b000);
    drain();

`ifdef BEEP_ABORT_EN
    // Abort in the gap: done on the next cycle, then idle
    n_idx = 1;
    for (int i = 0; i < ON; i++)
      push("abort", {(((i / H0) % 2) == 0) ? 1'b1 : 1'b0, 1'b1, 1'b0});
    push("abort", 3'b010);
    push("abort", 3'b010);
    push("abort", 3'b011);
    push("abort", 3'b000);
    push("abort", 3'b000);
    tone_sel = 2'd0; beep_num = 3'd2; req = 1'b1;
    tick();
    req = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    drain();
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
